ldpc_syndrome_check: RTL and testbench

Receive-side counterpart of the LDPC parity encoder. Accepts a codeword streamed 8 bits per beat and accumulates the M-bit syndrome s = H·c (GF(2)) against a parameterised parity-check matrix. At end of frame it reports the syndrome, its Hamming weight, a pass flag and a framing-error flag through a valid/ready result port. It sits between the channel deserialiser and the (future) bit-flipping decoder, which consumes its syndrome output.

---
 rtl/ldpc_pkg.sv | 31 +++
 rtl/ldpc_syndrome_check_row_parity.sv | 18 +
 rtl/ldpc_syndrome_check.sv | 93 +++++++++
 tb/tb_ldpc_syndrome_check.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the LDPC syndrome checker: beat width, FSM states,
// popcount and parity-check matrix byte lookup.
package ldpc_pkg;

   localparam int CHUNK_W = 8;
   localparam int MAX_M   = 256;
   localparam int MAX_H_W = 16384;

   typedef enum logic {
      ACCUM,
      REPORT
   } state_t;

   function automatic int popcount(input logic [MAX_M-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_M; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

   // Byte of H for row m, chunk c, from a zero-extended flattened matrix.
   function automatic logic [CHUNK_W-1:0] h_byte(input logic [MAX_H_W-1:0] h,
                                                 input int m,
                                                 input int c,
                                                 input int chunks);
      return h[(m*chunks+c)*CHUNK_W +: CHUNK_W];
   endfunction

endpackage

// File: rtl/ldpc_syndrome_check_row_parity.sv
// One parity-check row slice: GF(2) dot product of a data beat with an H byte,
// pairing d_in[i] with h[7-i] to match the encoder cell bit order.
module ldpc_row_parity
   import ldpc_pkg::*;
(
   input  logic [CHUNK_W-1:0] d_in,
   input  logic [CHUNK_W-1:0] h,
   output logic               parity
);

   always_comb begin
      parity = 1'b0;
      for (int i = 0; i < CHUNK_W; i++) begin
         parity = parity ^ (d_in[i] & h[CHUNK_W-1-i]);
      end
   end

endmodule

// File: rtl/ldpc_syndrome_check.sv
// Streams a codeword in 8-bit beats, accumulates s = H*c over GF(2) and presents
// the syndrome, its weight, a pass flag and a framing-error flag on a valid/ready port.
module ldpc_syndrome_check
   import ldpc_pkg::*;
#(
   parameter int CHUNKS = 8,
   parameter int M      = 8,
   parameter logic [M*CHUNKS*8-1:0] H_MATRIX = {M*CHUNKS{8'hFF}}
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHUNK_W-1:0]        d_in,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [M-1:0]              syndrome,
   output logic                      syn_ok,
   output logic [$clog2(M+1)-1:0]    syn_weight,
   output logic                      frame_err
);

   localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int WW = $clog2(M+1);
   localparam logic [CW-1:0]      LAST_C = CW'(CHUNKS-1);
   localparam logic [MAX_H_W-1:0] H_EXT  = MAX_H_W'(H_MATRIX);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [M-1:0]   syn_q;
   logic [M-1:0]   par;
   logic           ferr_q;
   logic           is_last;

   generate
      for (genvar m = 0; m < M; m++) begin : g_row
         logic [CHUNK_W-1:0] h_sel;
         assign h_sel = h_byte(H_EXT, m, int'(cnt), CHUNKS);
         ldpc_row_parity u_row (
            .d_in   (d_in),
            .h      (h_sel),
            .parity (par[m])
         );
      end
   endgenerate

   assign is_last    = (cnt == LAST_C);
   assign in_ready   = (state == ACCUM) && !rst;
   assign syndrome   = syn_q;
   assign syn_ok     = (syn_q == '0);
   assign syn_weight = WW'(popcount(MAX_M'(syn_q)));
   assign frame_err  = ferr_q;

   // Framing is purely by beat count; in_last only feeds the sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         cnt       <= '0;
         syn_q     <= '0;
         ferr_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  syn_q <= syn_q ^ par;
                  if (in_last != is_last) begin
                     ferr_q <= 1'b1;
                  end
                  if (is_last) begin
                     cnt       <= '0;
                     state     <= REPORT;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            REPORT: begin
               if (out_ready) begin
                  syn_q     <= '0;
                  ferr_q    <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_syndrome_check.sv
// Directed bench for ldpc_syndrome_check: a small 2x2 H to pin down bit pairing,
// framing, backpressure and reset, plus the default 8x8 all-ones configuration.
module tb_ldpc_syndrome_check;

   logic clk;
   logic rst;

   logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
   logic [7:0] a_d_in;
   logic [1:0] a_syndrome;
   logic       a_syn_ok, a_frame_err;
   logic [1:0] a_syn_weight;

   logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
   logic [7:0] b_d_in;
   logic [7:0] b_syndrome;
   logic       b_syn_ok, b_frame_err;
   logic [3:0] b_syn_weight;

   int n_cmp = 0;
   int n_err = 0;

   ldpc_syndrome_check #(
      .CHUNKS   (2),
      .M        (2),
      .H_MATRIX (32'h0100_0080)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .d_in       (a_d_in),
      .in_last    (a_in_last),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .syndrome   (a_syndrome),
      .syn_ok     (a_syn_ok),
      .syn_weight (a_syn_weight),
      .frame_err  (a_frame_err)
   );

   ldpc_syndrome_check dut_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .d_in       (b_d_in),
      .in_last    (b_in_last),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .syndrome   (b_syndrome),
      .syn_ok     (b_syn_ok),
      .syn_weight (b_syn_weight),
      .frame_err  (b_frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one beat to DUT A and waits (bounded) for it to be taken.
   task automatic apply_stimulus_a(input logic [7:0] d, input logic last);
      bit taken;
      taken      = 1'b0;
      a_in_valid = 1'b1;
      a_d_in     = d;
      a_in_last  = last;
      for (int i = 0; i < 20 && !taken; i++) begin
         if (a_in_ready) taken = 1'b1;
         tick();
      end
      a_in_valid = 1'b0;
      a_in_last  = 1'b0;
      check_output("a_beat_accepted", 32'(taken), 32'd1);
   endtask

   task automatic apply_stimulus_b(input logic [7:0] d, input logic last);
      bit taken;
      taken      = 1'b0;
      b_in_valid = 1'b1;
      b_d_in     = d;
      b_in_last  = last;
      for (int i = 0; i < 20 && !taken; i++) begin
         if (b_in_ready) taken = 1'b1;
         tick();
      end
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      check_output("b_beat_accepted", 32'(taken), 32'd1);
   endtask

   task automatic check_result_a(input string tag, input logic [1:0] syn, input logic [1:0] wt,
                                 input logic ok, input logic fe);
      check_output({tag, "_valid"},  32'(a_out_valid),  32'd1);
      check_output({tag, "_syn"},    32'(a_syndrome),   32'(syn));
      check_output({tag, "_weight"}, 32'(a_syn_weight), 32'(wt));
      check_output({tag, "_ok"},     32'(a_syn_ok),     32'(ok));
      check_output({tag, "_ferr"},   32'(a_frame_err),  32'(fe));
   endtask

   task automatic pop_a(input string tag);
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      check_output({tag, "_pop_valid"}, 32'(a_out_valid), 32'd0);
      check_output({tag, "_pop_ready"}, 32'(a_in_ready),  32'd1);
      check_output({tag, "_pop_syn"},   32'(a_syndrome),  32'd0);
   endtask

   task automatic frame_b(input int pos, input logic [7:0] val);
      for (int k = 0; k < 8; k++) begin
         apply_stimulus_b((k == pos) ? val : 8'h00, k == 7);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_d_in = 8'h00; a_in_last = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_d_in = 8'h00; b_in_last = 1'b0; b_out_ready = 1'b0;

      tick();
      tick();
      check_output("rst_in_ready",  32'(a_in_ready),   32'd0);
      check_output("rst_out_valid", 32'(a_out_valid),  32'd0);
      check_output("rst_syn",       32'(a_syndrome),   32'd0);
      check_output("rst_ok",        32'(a_syn_ok),     32'd1);
      check_output("rst_weight",    32'(a_syn_weight), 32'd0);
      check_output("rst_b_ready",   32'(b_in_ready),   32'd0);
      rst = 1'b0;
      tick();
      check_output("post_rst_ready", 32'(a_in_ready), 32'd1);

      // Beats 01,00: d[0] pairs with h[7] of row0/chunk0 (0x80).
      apply_stimulus_a(8'h01, 1'b0);
      check_output("f1_mid_valid", 32'(a_out_valid), 32'd0);
      apply_stimulus_a(8'h00, 1'b1);
      check_result_a("f1", 2'b01, 2'd1, 1'b0, 1'b0);

      // Backpressure: result held while input is offered and stalled.
      a_in_valid = 1'b1;
      a_d_in     = 8'hFF;
      a_in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_output("bp_in_ready",  32'(a_in_ready),  32'd0);
         check_output("bp_out_valid", 32'(a_out_valid), 32'd1);
         check_output("bp_syn",       32'(a_syndrome),  32'd1);
      end
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b0;
      a_in_last   = 1'b0;
      check_output("bp_release_valid", 32'(a_out_valid), 32'd0);
      check_output("bp_release_ready", 32'(a_in_ready),  32'd1);

      // Beats 00,80: d[7] pairs with h[0] of row1/chunk1 (0x01).
      apply_stimulus_a(8'h00, 1'b0);
      apply_stimulus_a(8'h80, 1'b1);
      check_result_a("f2", 2'b10, 2'd1, 1'b0, 1'b0);
      pop_a("f2");

      // Beats 80,01 miss every reversed pairing.
      apply_stimulus_a(8'h80, 1'b0);
      apply_stimulus_a(8'h01, 1'b1);
      check_result_a("f3", 2'b00, 2'd0, 1'b1, 1'b0);
      pop_a("f3");

      // Early in_last, then missing in_last: error flagged, framing by count.
      apply_stimulus_a(8'h01, 1'b1);
      check_output("fe_no_early_valid", 32'(a_out_valid), 32'd0);
      apply_stimulus_a(8'h80, 1'b0);
      check_result_a("fe", 2'b11, 2'd2, 1'b0, 1'b1);
      pop_a("fe");
      apply_stimulus_a(8'h01, 1'b0);
      apply_stimulus_a(8'h00, 1'b1);
      check_result_a("fe_clean", 2'b01, 2'd1, 1'b0, 1'b0);
      pop_a("fe_clean");

      // Reset mid-frame discards the partial syndrome and counter.
      apply_stimulus_a(8'h01, 1'b0);
      rst = 1'b1;
      tick();
      check_output("mid_rst_ready", 32'(a_in_ready), 32'd0);
      rst = 1'b0;
      tick();
      check_output("mid_rst_valid", 32'(a_out_valid), 32'd0);
      check_output("mid_rst_syn",   32'(a_syndrome),  32'd0);
      apply_stimulus_a(8'h00, 1'b0);
      check_output("mid_rst_no_valid", 32'(a_out_valid), 32'd0);
      apply_stimulus_a(8'h80, 1'b1);
      check_result_a("mid_rst", 2'b10, 2'd1, 1'b0, 1'b0);
      pop_a("mid_rst");

      // Default configuration: 8 chunks, 8 rows, H all ones.
      frame_b(0, 8'h00);
      check_output("b_zero_valid", 32'(b_out_valid),  32'd1);
      check_output("b_zero_syn",   32'(b_syndrome),   32'h00);
      check_output("b_zero_ok",    32'(b_syn_ok),     32'd1);
      check_output("b_zero_ferr",  32'(b_frame_err),  32'd0);
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
      check_output("b_pop_valid", 32'(b_out_valid), 32'd0);
      frame_b(3, 8'h08);
      check_output("b_one_valid",  32'(b_out_valid),  32'd1);
      check_output("b_one_syn",    32'(b_syndrome),   32'hFF);
      check_output("b_one_weight", 32'(b_syn_weight), 32'd8);
      check_output("b_one_ok",     32'(b_syn_ok),     32'd0);
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
      frame_b(5, 8'h3C);
      check_output("b_even_syn", 32'(b_syndrome), 32'h00);
      check_output("b_even_ok",  32'(b_syn_ok),   32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
